// File: rtl/camera_ctrl_if.sv
// camera_ctrl_if: per-frame link between game logic/scroller and the camera controller.
interface camera_ctrl_if;
   logic [10:0] player_x;
   logic [10:0] screen_x_min;
   logic        lock_req;
   logic [10:0] lock_x;
   logic        shake_trig;
   logic [10:0] roll;
   logic [10:0] offset;
   logic [1:0]  cam_state;
   logic        at_edge;
   logic        shake_active;
   modport master (
      output player_x, screen_x_min, lock_req, lock_x, shake_trig,
      input  roll, offset, cam_state, at_edge, shake_active
   );
   modport slave (
      input  player_x, screen_x_min, lock_req, lock_x, shake_trig,
      output roll, offset, cam_state, at_edge, shake_active
   );
endinterface

// File: rtl/camera_ctrl.sv
// camera_ctrl: once-per-frame scroll step and vertical offset for the background scroller.
// Build option CAMERA_BACKSCROLL_EN enables leftward scrolling and two-way lock seeking.
module camera_ctrl #(
   parameter int LEFT_ZONE    = 160,
   parameter int RIGHT_ZONE   = 400,
   parameter int MAX_STEP     = 4,
   parameter int X_MIN_LIMIT  = 5,
   parameter int X_MAX_LIMIT  = 360,
   parameter int BASE_OFFSET  = 0,
   parameter int SHAKE_AMP    = 2,
   parameter int SHAKE_FRAMES = 8
) (
   input  logic         Clk,
   input  logic         Reset,
   input  logic         i_frame_clk,
   camera_ctrl_if.slave cam
);
`ifdef CAMERA_BACKSCROLL_EN
   localparam bit BACK = 1'b1;
`else
   localparam bit BACK = 1'b0;
`endif
   localparam int CW = $clog2(SHAKE_FRAMES + 1);
   typedef logic signed [12:0] s13_t;
   typedef enum logic [1:0] {FOLLOW, LOCK_SEEK, LOCKED} state_t;
   localparam s13_t P_LEFT  = s13_t'(LEFT_ZONE);
   localparam s13_t P_RIGHT = s13_t'(RIGHT_ZONE);
   localparam s13_t P_MAX   = s13_t'(MAX_STEP);
   localparam s13_t P_XMIN  = s13_t'(X_MIN_LIMIT);
   localparam s13_t P_XMAX  = s13_t'(X_MAX_LIMIT);
   state_t        r_state, w_next;
   logic [1:0]    r_sync, r_vld;
   logic          r_prev, r_pend, w_tick;
   logic [CW-1:0] r_cnt, w_cnt;
   logic [10:0]   r_roll, r_offset, w_px, w_roll;
   s13_t          w_pxs, w_sxm, w_follow, w_seek, w_raw, w_step, w_edge;
   assign w_tick = r_sync[1] & ~r_prev;
   assign w_next = !cam.lock_req ? FOLLOW :
                   r_state == FOLLOW ? LOCK_SEEK :
                   (r_state == LOCK_SEEK && (cam.screen_x_min == cam.lock_x ||
                    (!BACK && cam.lock_x < cam.screen_x_min))) ? LOCKED : r_state;
   assign w_px     = cam.player_x < cam.screen_x_min ? 11'd0 : cam.player_x - cam.screen_x_min;
   assign w_pxs    = s13_t'({2'b00, w_px});
   assign w_sxm    = s13_t'({2'b00, cam.screen_x_min});
   assign w_follow = w_pxs > P_RIGHT ? w_pxs - P_RIGHT : w_pxs < P_LEFT ? w_pxs - P_LEFT : '0;
   assign w_seek   = s13_t'({2'b00, cam.lock_x}) - w_sxm;
   assign w_raw    = w_next == LOCKED ? '0 : w_next == LOCK_SEEK ? w_seek : w_follow;
   assign w_step   = w_raw > P_MAX ? P_MAX : w_raw < -P_MAX ? -P_MAX : w_raw;
   // keep screen_x_min + roll inside the legal scroll window
   assign w_edge   = w_step > P_XMAX - w_sxm ? P_XMAX - w_sxm :
                     w_step < P_XMIN - w_sxm ? P_XMIN - w_sxm : w_step;
   assign w_roll   = (!BACK && w_edge[12]) ? 11'd0 : 11'(w_edge);
   assign w_cnt    = (r_pend | cam.shake_trig) ? CW'(SHAKE_FRAMES) :
                     r_cnt != '0 ? r_cnt - CW'(1) : r_cnt;
   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_sync   <= '0;
         r_vld    <= '0;
         r_prev   <= 1'b1;
         r_pend   <= 1'b0;
         r_cnt    <= '0;
         r_state  <= FOLLOW;
         r_roll   <= '0;
         r_offset <= 11'(BASE_OFFSET);
      end else begin
         r_sync <= {r_sync[0], i_frame_clk};
         r_vld  <= {r_vld[0], 1'b1};
         // edge detector stays disarmed until post-reset samples arrive, dropping an edge caught by reset
         r_prev <= r_vld[1] ? r_sync[1] : 1'b1;
         r_pend <= w_tick ? 1'b0 : (r_pend | cam.shake_trig);
         if (w_tick) begin
            r_state  <= w_next;
            r_roll   <= w_roll;
            r_cnt    <= w_cnt;
            r_offset <= 11'(BASE_OFFSET) + (w_cnt[0] ? 11'(SHAKE_AMP) : 11'd0);
         end
      end
   end
   assign cam.roll         = r_roll;
   assign cam.offset       = r_offset;
   assign cam.cam_state    = r_state;
   assign cam.at_edge      = cam.screen_x_min == 11'(X_MIN_LIMIT) || cam.screen_x_min == 11'(X_MAX_LIMIT);
   assign cam.shake_active = r_cnt != '0;
endmodule

// File: tb/tb_camera_ctrl.sv
// tb_camera_ctrl: scoreboard bench for camera_ctrl; expectations follow the CAMERA_BACKSCROLL_EN build setting.
module tb_camera_ctrl;
   logic Clk = 1'b0;
   logic Reset = 1'b1;
   logic frame_clk = 1'b0;
   int n_chk = 0;
   int n_fail = 0;
   typedef struct {logic [10:0] roll; logic [1:0] state; logic [10:0] offset; logic active;} exp_t;
   exp_t sb[$];
   exp_t e;
`ifdef CAMERA_BACKSCROLL_EN
   localparam bit BK = 1'b1;
`else
   localparam bit BK = 1'b0;
`endif
   camera_ctrl_if cam();
   camera_ctrl dut (.Clk(Clk), .Reset(Reset), .i_frame_clk(frame_clk), .cam(cam));
   always #5 Clk = ~Clk;

   task automatic do_frame();
      @(negedge Clk) frame_clk = 1'b1;
      repeat (3) @(posedge Clk);
      @(negedge Clk) frame_clk = 1'b0;
      repeat (4) @(negedge Clk);
   endtask

   task automatic test_reset();
      cam.player_x = 11'd0; cam.screen_x_min = 11'd5; cam.lock_req = 1'b0;
      cam.lock_x = 11'd0; cam.shake_trig = 1'b0; Reset = 1'b1;
      repeat (3) @(negedge Clk);
      n_chk++; if (cam.roll !== 11'd0) begin n_fail++; $display("FAIL reset_roll got %h want 000", cam.roll); end
      n_chk++; if (cam.offset !== 11'd0) begin n_fail++; $display("FAIL reset_offset got %h want 000", cam.offset); end
      n_chk++; if (cam.cam_state !== 2'd0) begin n_fail++; $display("FAIL reset_state got %0d want 0", cam.cam_state); end
      n_chk++; if (cam.shake_active !== 1'b0) begin n_fail++; $display("FAIL reset_shake got %b want 0", cam.shake_active); end
      n_chk++; if (cam.at_edge !== 1'b1) begin n_fail++; $display("FAIL reset_at_edge_min got %b want 1", cam.at_edge); end
      cam.screen_x_min = 11'd100; #1;
      n_chk++; if (cam.at_edge !== 1'b0) begin n_fail++; $display("FAIL at_edge_mid got %b want 0", cam.at_edge); end
      @(negedge Clk) Reset = 1'b0;
      repeat (4) @(negedge Clk);
   endtask

   task automatic test_follow();
      cam.screen_x_min = 11'd100; cam.player_x = 11'd510;
      sb.push_back('{11'd4, 2'd0, 11'd0, 1'b0});
      @(negedge Clk) frame_clk = 1'b1;
      repeat (2) @(posedge Clk);
      @(negedge Clk);
      n_chk++; if (cam.roll !== 11'd0) begin n_fail++; $display("FAIL follow_latency got %h want 000", cam.roll); end
      @(negedge Clk) frame_clk = 1'b0;
      e = sb.pop_front();
      n_chk++; if (cam.roll !== e.roll) begin n_fail++; $display("FAIL follow_510 got %h want %h", cam.roll, e.roll); end
      repeat (4) @(negedge Clk);
      for (int i = 0; i < 2; i++) begin
         cam.player_x = i == 0 ? 11'd502 : 11'd300;
         sb.push_back('{i == 0 ? 11'd2 : 11'd0, 2'd0, 11'd0, 1'b0});
         do_frame();
         e = sb.pop_front();
         n_chk++; if (cam.roll !== e.roll) begin n_fail++; $display("FAIL follow_%0d got %h want %h", i, cam.roll, e.roll); end
      end
   endtask

   task automatic test_edge();
      cam.screen_x_min = 11'd358; cam.player_x = 11'd900;
      sb.push_back('{11'd2, 2'd0, 11'd0, 1'b0});
      sb.push_back('{11'd0, 2'd0, 11'd0, 1'b0});
      for (int i = 0; i < 2; i++) begin
         do_frame();
         e = sb.pop_front();
         n_chk++; if (cam.roll !== e.roll) begin n_fail++; $display("FAIL edge_roll_%0d got %h want %h", i, cam.roll, e.roll); end
         cam.screen_x_min = cam.screen_x_min + cam.roll; #1;
         n_chk++; if (cam.at_edge !== 1'b1) begin n_fail++; $display("FAIL edge_at_edge_%0d got %b want 1", i, cam.at_edge); end
      end
   endtask

   task automatic test_backscroll();
      sb.push_back('{BK ? 11'h7FC : 11'd0, 2'd0, 11'd0, 1'b0});
      sb.push_back('{BK ? 11'h7FE : 11'd0, 2'd0, 11'd0, 1'b0});
      for (int i = 0; i < 2; i++) begin
         cam.screen_x_min = i == 0 ? 11'd200 : 11'd7;
         cam.player_x = i == 0 ? 11'd250 : 11'd10;
         do_frame();
         e = sb.pop_front();
         n_chk++; if (cam.roll !== e.roll) begin n_fail++; $display("FAIL back_roll_%0d got %h want %h", i, cam.roll, e.roll); end
      end
   endtask

   task automatic test_lock();
      cam.player_x = 11'd400; cam.screen_x_min = 11'd110; cam.lock_x = 11'd120; cam.lock_req = 1'b1;
      sb.push_back('{11'd4, 2'd1, 11'd0, 1'b0});
      sb.push_back('{11'd4, 2'd1, 11'd0, 1'b0});
      sb.push_back('{11'd2, 2'd1, 11'd0, 1'b0});
      sb.push_back('{11'd0, 2'd2, 11'd0, 1'b0});
      sb.push_back('{11'd0, 2'd2, 11'd0, 1'b0});
      sb.push_back('{11'd0, 2'd0, 11'd0, 1'b0});
      sb.push_back('{BK ? 11'h7FC : 11'd0, 2'd1, 11'd0, 1'b0});
      sb.push_back('{BK ? 11'h7FC : 11'd0, BK ? 2'd1 : 2'd2, 11'd0, 1'b0});
      sb.push_back('{11'd0, 2'd0, 11'd0, 1'b0});
      for (int i = 0; i < 9; i++) begin
         cam.lock_req = !(i == 5 || i == 8);
         if (i == 6) begin cam.lock_x = 11'd100; cam.screen_x_min = 11'd120; end
         do_frame();
         e = sb.pop_front();
         n_chk++; if (cam.roll !== e.roll) begin n_fail++; $display("FAIL lock_roll_%0d got %h want %h", i, cam.roll, e.roll); end
         n_chk++; if (cam.cam_state !== e.state) begin n_fail++; $display("FAIL lock_state_%0d got %0d want %0d", i, cam.cam_state, e.state); end
         cam.screen_x_min = cam.screen_x_min + cam.roll;
      end
   endtask

   task automatic test_shake();
      int c;
      cam.screen_x_min = 11'd100; cam.player_x = 11'd300;
      @(negedge Clk) cam.shake_trig = 1'b1;
      @(negedge Clk) cam.shake_trig = 1'b0;
      n_chk++; if (cam.shake_active !== 1'b0) begin n_fail++; $display("FAIL shake_pending got %b want 0", cam.shake_active); end
      for (int f = 0; f < 9; f++) sb.push_back('{11'd0, 2'd0, (f < 8 && f % 2 == 1) ? 11'd2 : 11'd0, f < 8});
      for (int f = 0; f < 13; f++) begin
         c = f < 4 ? 8 - f : 12 - f;
         sb.push_back('{11'd0, 2'd0, c % 2 == 1 ? 11'd2 : 11'd0, c != 0});
      end
      for (int f = 0; f < 22; f++) begin
         if (f == 9 || f == 13) begin
            @(negedge Clk) cam.shake_trig = 1'b1;
            @(negedge Clk) cam.shake_trig = 1'b0;
         end
         do_frame();
         e = sb.pop_front();
         n_chk++; if (cam.offset !== e.offset) begin n_fail++; $display("FAIL shake_offset_%0d got %h want %h", f, cam.offset, e.offset); end
         n_chk++; if (cam.shake_active !== e.active) begin n_fail++; $display("FAIL shake_active_%0d got %b want %b", f, cam.shake_active, e.active); end
      end
      @(negedge Clk) frame_clk = 1'b1;
      repeat (2) @(posedge Clk);
      @(negedge Clk) cam.shake_trig = 1'b1;
      @(negedge Clk) begin cam.shake_trig = 1'b0; frame_clk = 1'b0; end
      repeat (4) @(negedge Clk);
      n_chk++; if (cam.shake_active !== 1'b1) begin n_fail++; $display("FAIL shake_same_cycle got %b want 1", cam.shake_active); end
      do_frame();
      n_chk++; if (cam.offset !== 11'd2) begin n_fail++; $display("FAIL shake_no_repend got %h want 002", cam.offset); end
   endtask

   task automatic test_reset_mid_frame();
      cam.player_x = 11'd400; cam.screen_x_min = 11'd100; cam.lock_x = 11'd300; cam.lock_req = 1'b1;
      do_frame();
      n_chk++; if (cam.roll !== 11'd4) begin n_fail++; $display("FAIL rmid_pre_roll got %h want 004", cam.roll); end
      @(negedge Clk) frame_clk = 1'b1;
      @(negedge Clk) Reset = 1'b1;
      @(negedge Clk) Reset = 1'b0;
      n_chk++; if (cam.roll !== 11'd0) begin n_fail++; $display("FAIL rmid_roll got %h want 000", cam.roll); end
      n_chk++; if (cam.cam_state !== 2'd0) begin n_fail++; $display("FAIL rmid_state got %0d want 0", cam.cam_state); end
      n_chk++; if (cam.shake_active !== 1'b0) begin n_fail++; $display("FAIL rmid_shake got %b want 0", cam.shake_active); end
      repeat (6) @(negedge Clk);
      n_chk++; if (cam.roll !== 11'd0) begin n_fail++; $display("FAIL rmid_discard_roll got %h want 000", cam.roll); end
      n_chk++; if (cam.cam_state !== 2'd0) begin n_fail++; $display("FAIL rmid_discard_state got %0d want 0", cam.cam_state); end
      frame_clk = 1'b0; cam.lock_req = 1'b0;
      repeat (4) @(negedge Clk);
   endtask

   initial begin
      test_reset();
      test_follow();
      test_edge();
      test_backscroll();
      test_lock();
      test_shake();
      test_reset_mid_frame();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/camera_ctrl.md
# camera_ctrl

Per-frame camera controller that sits directly upstream of the background scroller. Once per frame it computes the signed horizontal scroll step `roll` and the vertical map offset `offset` that the scroller consumes. It uses the player's world X position, the scroller's current `Screen_X_Min` (fed back), a scene-lock request from game logic, and a screen-shake trigger.

## Interface
Parameters:
- `LEFT_ZONE`, 160: on-screen X below which the camera scrolls left (backscroll builds only).
- `RIGHT_ZONE`, 400: on-screen X above which the camera scrolls right.
- `MAX_STEP`, 4: maximum |roll| per frame.
- `X_MIN_LIMIT`, 5: lowest legal `Screen_X_Min`.
- `X_MAX_LIMIT`, 360: highest legal `Screen_X_Min` (map width 1000 − screen width 640).
- `BASE_OFFSET`, 0: nominal vertical offset.
- `SHAKE_AMP`, 2: shake displacement added to `offset`.
- `SHAKE_FRAMES`, 8: shake duration in frames.

Ports:
- `Clk` in 1: 50 MHz clock.
- `Reset` in 1: reset, synchronous, active-high.
- `frame_clk` in 1: ~60 Hz frame clock; asynchronous to `Clk`.
- `player_x` in 11: player world X, unsigned.
- `screen_x_min` in 11: scroller's current `Screen_X_Min`.
- `lock_req` in 1: level-sensitive request to lock the scene at `lock_x`.
- `lock_x` in 11: target `Screen_X_Min` for the lock.
- `shake_trig` in 1: single-`Clk` pulse that starts a shake.
- `roll` out 11: signed two's-complement scroll step, held for one frame.
- `offset` out 11: vertical map offset, unsigned.
- `cam_state` out 2: 0 FOLLOW, 1 LOCK_SEEK, 2 LOCKED.
- `at_edge` out 1: `screen_x_min` equals `X_MIN_LIMIT` or `X_MAX_LIMIT`.
- `shake_active` out 1: shake counter nonzero.

## Operation
- `frame_clk` passes through a 2-FF synchronizer. A rising-edge detector produces a one-`Clk` `frame_tick`. All state, `roll` and `offset` update only on `frame_tick`.
- Screen-relative player position: `px = player_x − screen_x_min`, 11-bit. If `player_x < screen_x_min`, `px` is treated as 0.
- FOLLOW state:
  - `px > RIGHT_ZONE`: raw = `px − RIGHT_ZONE`.
  - `px < LEFT_ZONE`: raw = −(`LEFT_ZONE − px`). Backscroll builds only; otherwise raw = 0.
  - Otherwise raw = 0.
  - raw is clamped to ±`MAX_STEP`.
- LOCK_SEEK state: raw = `lock_x − screen_x_min`, clamped to ±`MAX_STEP`. Player position is ignored.
- LOCKED state: roll = 0.
- Edge clamp applies after the step clamp. `roll` is reduced so that `screen_x_min + roll` stays within [`X_MIN_LIMIT`, `X_MAX_LIMIT`].
- Sign convention: `roll` is two's complement. The scroller's 11-bit unsigned add wraps modulo 2048 and yields the correct decrement.
- FSM transitions, evaluated on `frame_tick`:
  - FOLLOW → LOCK_SEEK when `lock_req` = 1.
  - LOCK_SEEK → LOCKED when `screen_x_min == lock_x`.
  - Without backscroll: LOCK_SEEK → LOCKED immediately when `lock_x < screen_x_min`. The scene locks at its current position.
  - Any state → FOLLOW when `lock_req` = 0. Lock has priority over release in the same frame only if `lock_req` is still high.
  - `lock_x` is sampled every frame while in LOCK_SEEK. A change redirects the seek.
- Shake:
  - `shake_trig` sets a pending flag on any `Clk` cycle.
  - On the next `frame_tick`, `shake_cnt` loads `SHAKE_FRAMES` and pending clears.
  - On each later `frame_tick` with `shake_cnt > 0`, the counter decrements.
  - `offset` = `BASE_OFFSET + (shake_cnt[0] ? SHAKE_AMP : 0)`.
  - A retrigger while active reloads the counter.
  - Trigger and tick in the same cycle: the load occurs on that tick.
- `at_edge` and `shake_active` are combinational from registered and input values.

## Timing
- Reset values: `roll` = 0, `offset` = `BASE_OFFSET`, `cam_state` = FOLLOW, `shake_cnt` = 0, `shake_active` = 0, pending = 0, synchronizer = 0.
- `at_edge` is derived from `screen_x_min`; it is 1 during reset if the input is at a limit.
- `roll`/`offset` change 3 `Clk` cycles after a `frame_clk` rising edge: 2 synchronizer cycles plus 1 register cycle.
- Values are held stable until the next frame. The scroller samples them at the following `frame_clk` edge, giving one frame of lag by design.
- `screen_x_min` has settled (1 `Clk` after `frame_clk`) before `frame_tick`.
- Reset mid-frame: all outputs return to reset values next `Clk`. A `frame_clk` edge in progress is discarded.

## Configuration
- `CAMERA_BACKSCROLL_EN`:
  - Defined: left dead-zone active, negative `roll` permitted, LOCK_SEEK seeks in both directions.
  - Undefined: `roll` is never negative (forward-only beat-'em-up scrolling). `LEFT_ZONE` is unused. LOCK_SEEK locks in place when `lock_x < screen_x_min`.

## Test plan
- Reset, then `screen_x_min` = 100, `player_x` = 510, one frame → `roll` = 4. With `player_x` = 502 → `roll` = 2.
- `screen_x_min` = 358, `player_x` = 900 → `roll` = 2, then `at_edge` = 1 once `screen_x_min` = 360. Next frame `roll` = 0.
- Backscroll enabled, `screen_x_min` = 200, `player_x` = 250 → `roll` = 11'h7FC (−4). Backscroll disabled, same stimulus → `roll` = 0.
- `lock_req` = 1, `lock_x` = 120, `screen_x_min` = 110:
  - `cam_state` = 1, `roll` = 4, 4, 2 across frames (scroller follows), then `cam_state` = 2 with `roll` = 0.
  - Drop `lock_req` → `cam_state` = 0 next frame.
- `shake_trig` pulse mid-frame:
  - `offset` = 0, 2, 0, 2, … for 8 frames, then `shake_active` = 0 with `offset` = 0.
  - Retrigger at frame 5 → counter reloads to 8.
- Assert `Reset` 1 `Clk` after a `frame_clk` edge with `roll` = 4 → `roll` = 0, `cam_state` = 0. No update from the discarded edge.
